// File: rtl/queue_fifo_pkg.sv
// Shared widths, helpers and opcode type for the multi-lane circular queue.
package queue_fifo_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  // Pointers keep at least one bit so DEPTH values near 1 still elaborate.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  function automatic int unsigned lvl_width(input int unsigned depth);
    return clog2(depth + 1);
  endfunction

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_BOTH = 2'd3
  } q_op_e;

endpackage

// File: rtl/queue_fifo_if.sv
// Push/pop/status bundle for queue_fifo; QUEUE_FIFO_ERR_FLAGS_EN adds err_clr/ovf/unf.
interface queue_fifo_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned CHANNELS = 1
);
  localparam int unsigned DW    = WIDTH * CHANNELS;
  localparam int unsigned LVL_W = queue_fifo_pkg::lvl_width(DEPTH);

  logic             flush;
  logic             in_vld;
  logic             in_rdy;
  logic [DW-1:0]    din;
  logic             rd_en;
  logic [DW-1:0]    dout;
  logic             dout_vld;
  logic             full;
  logic             empty;
  logic [LVL_W-1:0] level;
`ifdef QUEUE_FIFO_ERR_FLAGS_EN
  logic             err_clr;
  logic             ovf;
  logic             unf;

  modport master (
    output flush, in_vld, din, rd_en, err_clr,
    input  in_rdy, dout, dout_vld, full, empty, level, ovf, unf
  );
  modport slave (
    input  flush, in_vld, din, rd_en, err_clr,
    output in_rdy, dout, dout_vld, full, empty, level, ovf, unf
  );
`else
  modport master (
    output flush, in_vld, din, rd_en,
    input  in_rdy, dout, dout_vld, full, empty, level
  );
  modport slave (
    input  flush, in_vld, din, rd_en,
    output in_rdy, dout, dout_vld, full, empty, level
  );
`endif
endinterface

// File: rtl/queue_fifo_wrap_ptr.sv
// Modulo-DEPTH pointer: wraps DEPTH-1 -> 0, never visits unused codes.
module queue_wrap_ptr #(
  parameter  int unsigned DEPTH = 3,
  localparam int unsigned PTR_W = queue_fifo_pkg::ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + PTR_W'(1);
    end
  end
endmodule

// File: rtl/queue_fifo.sv
// Multi-lane circular FIFO with registered read data and level/full/empty status.
// Optional QUEUE_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow flags.
module queue_fifo
  import queue_fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned CHANNELS = 1
) (
  input  logic         clk,
  input  logic         rst,
  queue_fifo_if.slave  q
);
  localparam int unsigned DW    = WIDTH * CHANNELS;
  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned LVL_W = lvl_width(DEPTH);

  logic [DW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [LVL_W-1:0] level_r;
  logic [DW-1:0]    dout_r;
  logic             dout_vld_r;
  logic             full_w;
  logic             empty_w;
  logic             push;
  logic             pop;
  q_op_e            op;

  // Status decodes from the registered level only; flush suppresses both requests.
  assign full_w  = (level_r == LVL_W'(DEPTH));
  assign empty_w = (level_r == '0);
  assign push    = q.in_vld && !full_w && !q.flush;
  assign pop     = q.rd_en  && !empty_w && !q.flush;

  always_comb begin
    op = OP_HOLD;
    unique case ({pop, push})
      2'b01:   op = OP_PUSH;
      2'b10:   op = OP_POP;
      2'b11:   op = OP_BOTH;
      default: op = OP_HOLD;
    endcase
  end

  queue_wrap_ptr #(.DEPTH(DEPTH)) u_wptr (
    .clk (clk),
    .rst (rst),
    .clr (q.flush),
    .inc (push),
    .ptr (wptr)
  );

  queue_wrap_ptr #(.DEPTH(DEPTH)) u_rptr (
    .clk (clk),
    .rst (rst),
    .clr (q.flush),
    .inc (pop),
    .ptr (rptr)
  );

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= q.din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_r    <= '0;
      dout_r     <= '0;
      dout_vld_r <= 1'b0;
    end else begin
      dout_vld_r <= pop;
      if (pop) begin
        dout_r <= mem[rptr];
      end
      if (q.flush) begin
        level_r <= '0;
      end else begin
        unique case (op)
          OP_PUSH: level_r <= level_r + LVL_W'(1);
          OP_POP:  level_r <= level_r - LVL_W'(1);
          default: level_r <= level_r;
        endcase
      end
    end
  end

  assign q.in_rdy   = !full_w;
  assign q.full     = full_w;
  assign q.empty    = empty_w;
  assign q.level    = level_r;
  assign q.dout     = dout_r;
  assign q.dout_vld = dout_vld_r;

`ifdef QUEUE_FIFO_ERR_FLAGS_EN
  logic ovf_r;
  logic unf_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else if (q.err_clr) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      if (q.in_vld && full_w) ovf_r <= 1'b1;
      if (q.rd_en && empty_w) unf_r <= 1'b1;
    end
  end

  assign q.ovf = ovf_r;
  assign q.unf = unf_r;
`endif

endmodule

// File: doc/queue_fifo.md
Name: queue_fifo

Overview:
Parametrised multi-lane circular FIFO that replaces the shift-register queue in the conv/pool line-buffer path. Each entry holds CHANNELS lanes of WIDTH bits. All lanes share one set of pointers and flags. Adds full/empty/level status, non-power-of-2 depth wrap, synchronous flush and protected push/pop. Read data is registered, keeping the one-cycle read latency downstream logic already expects.

Parameters:
WIDTH, 8, bits per lane
DEPTH, 3, number of entries; legal range 2..1024; need not be a power of 2
CHANNELS, 1, parallel lanes per entry, stored and popped together

Ports:
clk  in  1  single clock; all logic on posedge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous clear of pointers and level; storage contents untouched
in_vld  in  1  push request
in_rdy  out  1  equals !full; push accepted when in_vld && in_rdy
din  in  WIDTH*CHANNELS  push data; lane k at [WIDTH*(k+1)-1 -: WIDTH]
rd_en  in  1  pop request; accepted when rd_en && !empty
dout  out  WIDTH*CHANNELS  registered pop data; holds its value between pops
dout_vld  out  1  one-cycle pulse, cycle after an accepted pop
full  out  1  level == DEPTH
empty  out  1  level == 0
level  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Clock/reset: one clock (clk); reset rst is asynchronous and active-high. Storage is not reset.
- Reset values: dout=0, dout_vld=0, level=0, wptr=rptr=0, empty=1, full=0, in_rdy=1.
- Storage: DEPTH x (WIDTH*CHANNELS) register array. wptr/rptr are $clog2(DEPTH) bits wide (minimum 1). Each pointer wraps from DEPTH-1 to 0; it never counts through unused codes.
- Push accepted (in_vld && !full): mem[wptr]<=din; wptr advances.
- Pop accepted (rd_en && !empty): dout<=mem[rptr] at the same edge; rptr advances; dout_vld=1 next cycle. Latency from rd_en to data is 1 cycle.
- Level update: push only => +1; pop only => -1; both accepted => unchanged.
- Simultaneous push and pop when empty: pop is rejected and push is accepted. Write-to-read bypass is not provided, so the new data becomes readable one cycle later.
- Simultaneous push and pop when full: push is rejected (in_rdy=0) and pop is accepted. Same-cycle refill is not allowed.
- Push when full: ignored; storage and wptr unchanged.
- Pop when empty: ignored; dout holds, dout_vld=0.
- flush has priority over push and pop in the same cycle: wptr=rptr=0, level=0, dout_vld=0, dout holds.
- full, empty and in_rdy are decoded from the registered level, so they are valid in the cycle after any change.
- Reset asserted mid-operation: all state clears immediately (asynchronously). After release, the queue is empty.

Optional Feature:
QUEUE_FIFO_ERR_FLAGS_EN
- Defined: adds input err_clr (1) and outputs ovf (1) and unf (1).
  - ovf is sticky-set by in_vld while full.
  - unf is sticky-set by rd_en while empty.
  - Both clear on rst or err_clr. err_clr wins over a same-cycle set.
- Undefined: none of these ports or registers exist. Illegal requests are silently dropped.

Decomposition:
- Shared package/include queue_defs.vh holds:
  - a CLOG2 function used for pointer and level widths;
  - the lane slice macro LANE(k) = [WIDTH*(k+1)-1 -: WIDTH];
  - localparams PTR_W and LVL_W.
- Sub-module queue_wrap_ptr (params DEPTH; ports clk, rst, clr, inc, ptr) contains the modulo-DEPTH counter. It is instantiated twice, for wptr and rptr.

Test Plan:
- WIDTH=8, DEPTH=3, CHANNELS=2, reset -> level=0, empty=1, full=0, in_rdy=1, dout=0.
- Push 0x0201, 0x0403, 0x0605 -> full=1, in_rdy=0, level=3. A 4th push of 0x0807 is ignored, and ovf=1 when the macro is defined.
- From full: pop x3 -> dout = 0x0201, 0x0403, 0x0605 on consecutive cycles, each with dout_vld=1 one cycle after rd_en. Then empty=1.
- Simultaneous push and pop in these states:
  - at level 1: level stays 1;
  - when empty: only the push is taken, level=1;
  - when full: only the pop is taken, level=2.
- Wrap test, DEPTH=5: run 12 push/pop pairs with an incrementing pattern -> output order is preserved across pointer wrap and the pointers never exceed 4.
- Flush at level 2 concurrent with rd_en -> level=0, dout_vld=0, dout unchanged. Assert rst mid-stream -> all outputs return to reset values without waiting for a clock edge.
